// File: rtl/fetch_stall_ctrl.sv
// Fetch-side stall/redirect executor: owns the PC and the IF/ID register,
// injects NOP bubbles after redirects and counts stalled cycles.
module fetch_stall_ctrl #(
    parameter int PC_W      = 9,
    parameter int INSTR_W   = 32,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    pc_inc,
    input  logic               ifid_write,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    imem_addr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic               ifid_valid,
    output logic [1:0]         fetch_state,
    output logic [CNT_W-1:0]   stall_cycles
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [INSTR_W-1:0] NOP        = INSTR_W'(32'h0000_0013);
    localparam logic [2:0]         FLUSH_INIT = 3'(FLUSH_CYC);
    localparam state_t             BR_STATE   = (FLUSH_CYC > 0) ? FLUSH : RUN;

    state_t            state, state_nxt;
    logic [2:0]        flush_cnt, flush_cnt_nxt;
    logic [PC_W-1:0]   pc, pc_nxt;
    logic              bubble, load;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        bubble        = 1'b0;
        load          = 1'b0;
        if (branch_taken) begin
            bubble        = 1'b1;
            flush_cnt_nxt = FLUSH_INIT;
            state_nxt     = BR_STATE;
        end else begin
            case (state)
                FLUSH: begin
                    bubble        = 1'b1;
                    flush_cnt_nxt = (flush_cnt == 3'd0) ? 3'd0 : flush_cnt - 3'd1;
                    // Last bubble cycle: hand off straight into whatever the hazard unit asks now
                    if (flush_cnt <= 3'd1)
                        state_nxt = ifid_write ? RUN : STALL;
                end
                RUN: begin
                    load = ifid_write;
                    if (!ifid_write)
                        state_nxt = STALL;
                end
                STALL: begin
                    load = ifid_write;
                    if (ifid_write)
                        state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign pc_nxt = branch_taken ? branch_target : pc + pc_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= '0;
            pc        <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            pc        <= pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_pc    <= '0;
            ifid_instr <= NOP;
            ifid_valid <= 1'b0;
        end else if (bubble) begin
            ifid_instr <= NOP;
            ifid_valid <= 1'b0;
        end else if (load) begin
            ifid_pc    <= pc;
            ifid_instr <= imem_rdata;
            ifid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (!ifid_write && !branch_taken && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end

    assign imem_addr   = pc;
    assign fetch_state = state;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed vector bench for fetch_stall_ctrl, with a second narrow-counter,
// zero-flush instance for saturation and the FLUSH_CYC=0 redirect path.
module tb_fetch_stall_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  pc_inc;
    logic        ifid_write;
    logic        branch_taken;
    logic [8:0]  branch_target;
    logic [31:0] imem_rdata, s_imem_rdata;
    logic [8:0]  imem_addr, ifid_pc, s_imem_addr, s_ifid_pc;
    logic [31:0] ifid_instr, s_ifid_instr;
    logic        ifid_valid, s_ifid_valid;
    logic [1:0]  fetch_state, s_fetch_state;
    logic [15:0] stall_cycles;
    logic [1:0]  s_stall_cycles;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'd0, a};
    endfunction

    assign imem_rdata   = instr_of(imem_addr);
    assign s_imem_rdata = instr_of(s_imem_addr);

    fetch_stall_ctrl #(.PC_W(9), .INSTR_W(32), .FLUSH_CYC(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .pc_inc(pc_inc), .ifid_write(ifid_write),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_rdata(imem_rdata), .imem_addr(imem_addr), .ifid_pc(ifid_pc),
        .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
        .fetch_state(fetch_state), .stall_cycles(stall_cycles)
    );

    fetch_stall_ctrl #(.PC_W(9), .INSTR_W(32), .FLUSH_CYC(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .pc_inc(pc_inc), .ifid_write(ifid_write),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_rdata(s_imem_rdata), .imem_addr(s_imem_addr), .ifid_pc(s_ifid_pc),
        .ifid_instr(s_ifid_instr), .ifid_valid(s_ifid_valid),
        .fetch_state(s_fetch_state), .stall_cycles(s_stall_cycles)
    );

    typedef struct {
        logic [8:0]  pc_inc;
        logic        w;
        logic        bt;
        logic [8:0]  tgt;
        logic [8:0]  e_pc;
        logic [8:0]  e_ipc;
        logic        e_v;
        logic [1:0]  e_st;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [8:0] inc, input logic w, input logic bt,
                                input logic [8:0] tgt, input logic [8:0] e_pc,
                                input logic [8:0] e_ipc, input logic e_v,
                                input logic [1:0] e_st, input logic [15:0] e_stall);
        vec_t v;
        v.pc_inc = inc; v.w = w; v.bt = bt; v.tgt = tgt;
        v.e_pc = e_pc; v.e_ipc = e_ipc; v.e_v = e_v; v.e_st = e_st; v.e_stall = e_stall;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [8:0] e_pc, input logic [8:0] e_ipc,
                           input logic e_v, input logic [1:0] e_st, input logic [15:0] e_stall);
        chk({tag, " imem_addr"}, 32'(imem_addr), 32'(e_pc));
        chk({tag, " ifid_valid"}, 32'(ifid_valid), 32'(e_v));
        if (e_v) chk({tag, " ifid_pc"}, 32'(ifid_pc), 32'(e_ipc));
        chk({tag, " ifid_instr"}, ifid_instr, e_v ? instr_of(e_ipc) : NOP);
        chk({tag, " fetch_state"}, 32'(fetch_state), 32'(e_st));
        chk({tag, " stall_cycles"}, 32'(stall_cycles), 32'(e_stall));
    endtask

    task automatic drive(input logic [8:0] inc, input logic w, input logic bt, input logic [8:0] tgt);
        pc_inc = inc; ifid_write = w; branch_taken = bt; branch_target = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(9'd0, 1'b1, 1'b0, 9'd0);
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
        chk_all("reset", 9'd0, 9'd0, 1'b0, 2'd0, 16'd0);
        chk("reset ifid_pc", 32'(ifid_pc), 32'd0);

        // T1 sequential fetch
        add(9'd4, 1, 0, 9'd0,   9'd4,   9'd0,   1, 2'd0, 16'd0);
        add(9'd4, 1, 0, 9'd0,   9'd8,   9'd4,   1, 2'd0, 16'd0);
        add(9'd4, 1, 0, 9'd0,   9'd12,  9'd8,   1, 2'd0, 16'd0);
        add(9'd4, 1, 0, 9'd0,   9'd16,  9'd12,  1, 2'd0, 16'd0);
        // T2 three-cycle stall then release
        add(9'd0, 0, 0, 9'd0,   9'd16,  9'd12,  1, 2'd1, 16'd1);
        add(9'd0, 0, 0, 9'd0,   9'd16,  9'd12,  1, 2'd1, 16'd2);
        add(9'd0, 0, 0, 9'd0,   9'd16,  9'd12,  1, 2'd1, 16'd3);
        add(9'd4, 1, 0, 9'd0,   9'd20,  9'd16,  1, 2'd0, 16'd3);
        // T3 redirect to 0x40, hazard unit holds pc during the flush bubble
        add(9'd4, 1, 1, 9'h40,  9'h40,  9'd16,  0, 2'd2, 16'd3);
        add(9'd0, 1, 0, 9'd0,   9'h40,  9'd16,  0, 2'd0, 16'd3);
        add(9'd4, 1, 0, 9'd0,   9'h44,  9'h40,  1, 2'd0, 16'd3);
        add(9'd4, 1, 0, 9'd0,   9'h48,  9'h44,  1, 2'd0, 16'd3);
        // T5 redirect with ifid_write=0, then flush exit into STALL
        add(9'd0, 0, 1, 9'h80,  9'h80,  9'h44,  0, 2'd2, 16'd3);
        add(9'd0, 0, 0, 9'd0,   9'h80,  9'h44,  0, 2'd1, 16'd4);
        add(9'd0, 1, 0, 9'd0,   9'h80,  9'h80,  1, 2'd0, 16'd4);
        add(9'd4, 1, 0, 9'd0,   9'h84,  9'h80,  1, 2'd0, 16'd4);
        // back-to-back redirects: second one lands during FLUSH
        add(9'd4, 1, 1, 9'h100, 9'h100, 9'h80,  0, 2'd2, 16'd4);
        add(9'd4, 1, 1, 9'h120, 9'h120, 9'h80,  0, 2'd2, 16'd4);
        add(9'd0, 1, 0, 9'd0,   9'h120, 9'h80,  0, 2'd0, 16'd4);
        add(9'd4, 1, 0, 9'd0,   9'h124, 9'h120, 1, 2'd0, 16'd4);
        // T4 wrap from 0x1FC
        add(9'd0, 1, 1, 9'h1FC, 9'h1FC, 9'h120, 0, 2'd2, 16'd4);
        add(9'd0, 1, 0, 9'd0,   9'h1FC, 9'h120, 0, 2'd0, 16'd4);
        add(9'd4, 1, 0, 9'd0,   9'h000, 9'h1FC, 1, 2'd0, 16'd4);
        add(9'd4, 1, 0, 9'd0,   9'h004, 9'h000, 1, 2'd0, 16'd4);

        foreach (vecs[i]) begin
            drive(vecs[i].pc_inc, vecs[i].w, vecs[i].bt, vecs[i].tgt);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ipc, vecs[i].e_v,
                    vecs[i].e_st, vecs[i].e_stall);
            chk($sformatf("vec%0d sat_stall", i), 32'(s_stall_cycles),
                (vecs[i].e_stall > 16'd3) ? 32'd3 : 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d nf_state", i), 32'(s_fetch_state),
                (vecs[i].e_st == 2'd2) ? 32'd0 : 32'(vecs[i].e_st));
        end

        // T6 asynchronous reset between edges while flushing
        drive(9'd4, 1'b1, 1'b1, 9'h60);
        step();
        chk("t6 pre state", 32'(fetch_state), 32'd2);
        drive(9'd0, 1'b1, 1'b0, 9'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("t6 async", 9'd0, 9'd0, 1'b0, 2'd0, 16'd0);
        chk("t6 async ifid_pc", 32'(ifid_pc), 32'd0);
        chk("t6 async sat_stall", 32'(s_stall_cycles), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(9'd4, 1'b1, 1'b0, 9'd0);
        step();
        chk_all("t6 resume1", 9'd4, 9'd0, 1'b1, 2'd0, 16'd0);
        step();
        chk_all("t6 resume2", 9'd8, 9'd4, 1'b1, 2'd0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
